// File: rtl/echo_pkg.sv
// Shared types and constants for the echo stage and the echo canceller.
package echo_pkg;

    localparam int DEF_DATA_W = 16;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

    localparam sample_t SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } echo_state_e;

endpackage

// File: rtl/echo_canceller_if.sv
// Valid/ready sample stream; master drives valid and data, slave drives ready.
interface echo_canceller_if #(
    parameter int DATA_W = 16
) ();
    logic                     valid;
    logic                     ready;
    logic signed [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/echo_history_ram.sv
// Circular history of past outputs: async read, sync write at one shared address, no reset,
// so it maps onto distributed (LUT) RAM.
module echo_history_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/echo_canceller.sv
// Recursive comb removing a single-tap echo: y[n] = x[n] - (y[n-D] >>> GAIN_SHIFT).
// Define ECHO_CANCEL_SAT_EN to clamp results and enable the sticky clip_flag; default wraps.
module echo_canceller
    import echo_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int DELAY_SAMPLES = 1024,
    parameter int GAIN_SHIFT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    echo_canceller_if.slave  in_s,
    echo_canceller_if.master out_s,
    output logic             clip_flag
);
    localparam int              PTR_W = $clog2(DELAY_SAMPLES);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DELAY_SAMPLES - 1);

    echo_state_e              state, state_nxt;
    logic [PTR_W-1:0]         ptr, fill_cnt;
    logic                     use_hist, ready, acc, out_vld;
    logic signed [DATA_W-1:0] hist_rd, y_dly, tap, y_nxt, y_q;

    assign ready       = !out_vld || out_s.ready;
    assign acc         = in_s.valid && ready;
    assign in_s.ready  = ready;
    assign out_s.valid = out_vld;
    assign out_s.data  = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == FILL && acc && fill_cnt == LAST) state_nxt = RUN;
    end

    // Until D outputs exist the history holds garbage, so the feedback term is forced to 0.
    always_comb begin
        use_hist = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            fill_cnt <= '0;
        end else if (acc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
            if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    echo_history_ram #(
        .DEPTH (DELAY_SAMPLES),
        .WIDTH (DATA_W)
    ) u_hist (
        .clk   (clk),
        .we    (acc),
        .addr  (ptr),
        .wdata (y_nxt),
        .rdata (hist_rd)
    );

    assign y_dly = use_hist ? hist_rd : '0;
    assign tap   = y_dly >>> GAIN_SHIFT;

`ifdef ECHO_CANCEL_SAT_EN
    logic signed [DATA_W:0] diff;
    logic                   clip_nxt;

    assign diff = {in_s.data[DATA_W-1], in_s.data} - {tap[DATA_W-1], tap};

    // Overflow shows as disagreement between the guard bit and the sign bit.
    always_comb begin
        clip_nxt = diff[DATA_W] ^ diff[DATA_W-1];
        y_nxt    = diff[DATA_W-1:0];
        if (clip_nxt)
            y_nxt = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                clip_flag <= 1'b0;
        else if (acc && clip_nxt)  clip_flag <= 1'b1;
    end
`else
    // The wide difference truncated to DATA_W bits equals a plain DATA_W-bit subtract.
    assign y_nxt     = in_s.data - tap;
    assign clip_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            y_q     <= '0;
        end else if (acc) begin
            out_vld <= 1'b1;
            y_q     <= y_nxt;
        end else if (out_s.ready) begin
            out_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_echo_canceller.sv
// Bench for echo_canceller: two instances (D=4 and D=5) fed the same stream, checked against
// an arithmetic reference model plus directed expected sequences.
module tb_echo_canceller;
    import echo_pkg::*;

    localparam int DW = 16;
    localparam int GS = 1;

    logic    clk = 1'b0;
    logic    rst_n = 1'b1;
    logic    iv = 1'b0;
    logic    ordy = 1'b1;
    sample_t xin = '0;

    always #5 clk = ~clk;

    echo_canceller_if #(.DATA_W(DW)) a_in (), a_out (), b_in (), b_out ();
    logic clip_a, clip_b;

    assign a_in.valid  = iv;
    assign a_in.data   = xin;
    assign a_out.ready = ordy;
    assign b_in.valid  = iv;
    assign b_in.data   = xin;
    assign b_out.ready = ordy;

    echo_canceller #(.DATA_W(DW), .DELAY_SAMPLES(4), .GAIN_SHIFT(GS)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_s(a_in), .out_s(a_out), .clip_flag(clip_a));
    echo_canceller #(.DATA_W(DW), .DELAY_SAMPLES(5), .GAIN_SHIFT(GS)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_s(b_in), .out_s(b_out), .clip_flag(clip_b));

    logic                 ir [2], ov [2], cf [2];
    logic signed [DW-1:0] ao [2];
    assign ir[0] = a_in.ready;  assign ov[0] = a_out.valid; assign ao[0] = a_out.data; assign cf[0] = clip_a;
    assign ir[1] = b_in.ready;  assign ov[1] = b_out.valid; assign ao[1] = b_out.data; assign cf[1] = clip_b;

`ifdef ECHO_CANCEL_SAT_EN
    localparam int SAT_Y4 = 32767;
    localparam int SAT_CLIP = 1;
`else
    localparam int SAT_Y4 = -19152;
    localparam int SAT_CLIP = 0;
`endif

    int nvec = 0, nerr = 0;
    int dl [2] = '{4, 5};
    int ys0 [$], ys1 [$];
    bit m_ov [2];
    int m_out [2];
    bit m_clip [2];

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_y(input int x, input int yd, output bit clip);
        int d;
        d = x - (yd >>> GS);
        clip = 1'b0;
`ifdef ECHO_CANCEL_SAT_EN
        if (d > 32767)       begin d = 32767;  clip = 1'b1; end
        else if (d < -32768) begin d = -32768; clip = 1'b1; end
`else
        d = ((d + 32768) & 32'h0000_FFFF) - 32768;
`endif
        return d;
    endfunction

    function automatic void model_clear();
        ys0.delete();
        ys1.delete();
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = 1'b0; m_out[k] = 0; m_clip[k] = 1'b0;
        end
    endfunction

    // Called at a negedge; applies one cycle of stimulus and checks the result at the next negedge.
    task automatic step(input bit v, input int x, input bit rdy, output bit acc_a);
        bit acc, c;
        int n, yd, y;
        iv = v; xin = sample_t'(x); ordy = rdy;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("in_ready%0d", k), ir[k], (!m_ov[k] || rdy) ? 1 : 0);
        @(posedge clk);
        acc_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            acc = v && (!m_ov[k] || rdy);
            if (acc) begin
                n  = (k == 0) ? ys0.size() : ys1.size();
                yd = (n >= dl[k]) ? ((k == 0) ? ys0[n-dl[k]] : ys1[n-dl[k]]) : 0;
                y  = ref_y(x, yd, c);
                if (k == 0) ys0.push_back(y); else ys1.push_back(y);
                m_out[k] = y; m_ov[k] = 1'b1; m_clip[k] = m_clip[k] | c;
            end else if (rdy) begin
                m_ov[k] = 1'b0;
            end
            if (k == 0) acc_a = acc;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid%0d", k), ov[k], m_ov[k] ? 1 : 0);
            chk($sformatf("audio_out%0d", k), ao[k], m_out[k]);
            chk($sformatf("clip_flag%0d", k), cf[k], m_clip[k] ? 1 : 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b1;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), ov[k], 0);
            chk($sformatf("rst_out%0d", k), ao[k], 0);
            chk($sformatf("rst_ready%0d", k), ir[k], 1);
            chk($sformatf("rst_clip%0d", k), cf[k], 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", ov[0], 0);
        chk("rst_hold_out", ao[0], 0);
        rst_n = 1'b1;
    endtask

    // Feeds xs in order, optionally stalling out_ready for stall_n cycles after y[0],
    // and checks each freshly presented output of the D=4 instance against ex.
    task automatic run_seq(input string nm, input int xs [$], input int ex [$], input int stall_n);
        int  idx = 0, left = stall_n, cyc = 0;
        bit  a, rdy;
        while (idx < xs.size() && cyc < 500) begin
            rdy = 1'b1;
            if (idx == 1 && left > 0) begin rdy = 1'b0; left--; end
            step(1'b1, xs[idx], rdy, a);
            if (a) begin
                if (ex.size() > 0) chk($sformatf("%s[%0d]", nm, idx), ao[0], ex[idx]);
                idx++;
            end
            cyc++;
        end
        if (idx < xs.size()) chk({nm, "_timeout"}, idx, xs.size());
    endtask

    initial begin
        int imp_x [$], imp_y [$], rt_x [$], rt_y [$], sat_x [$], sat_y [$], wr_x [$], none [$];
        bit a;

        imp_x = '{1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        imp_y = '{1000, 0, 0, 0, -500, 0, 0, 0, 250, 0, 0, 0, -125, 0, 0, 0, 63};
        rt_x  = '{1000, 0, 0, 0, 500, 0, 0, 0, 0, 0, 0, 0};
        rt_y  = '{1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        sat_x = '{-32768, 0, 0, 0, 30000, 0, 0, 0};
        sat_y = '{-32768, 0, 0, 0, SAT_Y4, 0, 0, 0};
        for (int i = 0; i < 20; i++) wr_x.push_back(100);

        @(negedge clk);
        do_reset();

        run_seq("impulse", imp_x, imp_y, 0);

        do_reset();
        run_seq("roundtrip", rt_x, rt_y, 0);

        do_reset();
        run_seq("sat", sat_x, sat_y, 0);
        chk("sat_clip", cf[0], SAT_CLIP);

        do_reset();
        run_seq("backpressure", imp_x, imp_y, 3);

        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, (i == 0) ? 1000 : 0, 1'b1, a);
        do_reset();
        run_seq("replay", imp_x, imp_y, 0);

        // D=5 instance is checked by the model for the constant-input wrap case.
        do_reset();
        run_seq("wrap", wr_x, none, 0);

        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 3) != 0, a);

        iv = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/echo_canceller.md
# echo_canceller

Inverse of the feed-forward echo stage: removes a single-tap echo of known delay and gain from a 16-bit PCM stream using a recursive (IIR) comb, y[n] = sat(x[n] − (y[n−D] >>> GAIN_SHIFT)). It sits on the receive side of the audio chain, after the channel or effect path that applied the echo. It passes samples through a valid/ready stream interface with one output register.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- DELAY_SAMPLES, 1024: echo delay D in accepted samples; legal range ≥ 2, any integer.
- GAIN_SHIFT, 1: echo gain as an arithmetic right shift (1 = ½); legal range 1..DATA_W−1.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  audio_in holds a valid sample.
- in_ready  output  1  block can accept a sample this cycle.
- audio_in  input  DATA_W  signed echoed sample x[n].
- out_valid  output  1  audio_out holds a valid sample.
- out_ready  input  1  downstream accepts audio_out this cycle.
- audio_out  output  DATA_W  signed cleaned sample y[n].
- clip_flag  output  1  sticky; set when any output was clamped.

## Operation
- Accept: in_valid && in_ready at a rising edge.
- in_ready = !out_valid || out_ready, so a new sample can be accepted in the same cycle as the held one drains.
- Delay line: D-entry circular history of *outputs* y, with one pointer ptr. On accept:
  - read entry[ptr] (= y[n−D]) combinationally;
  - write y[n] to entry[ptr];
  - ptr advances; ptr = D−1 wraps to 0.
- FSM states:
  - FILL (after reset): fill counter counts accepts 0..D−1 and the delayed term is forced to 0, so history memory needs no reset. Transition to RUN on the D-th accept.
  - RUN: delayed term comes from memory. No exit except reset.
- Arithmetic:
  - t = y[n−D] >>> GAIN_SHIFT (arithmetic shift, rounds toward −∞).
  - diff = sign-extended x − t, computed at DATA_W+1 bits.
  - Result reduced to DATA_W per Configuration.
- Stall: no accept means ptr, fill counter, state and memory are all unchanged.
- Reset values: in_ready 1, out_valid 0, audio_out 0, clip_flag 0, ptr 0, state FILL, fill counter 0.
- Reset asserted mid-stream: the held output is dropped, and the next accepted sample is treated as n=0 (history zero).

## Timing
- Latency: a sample accepted at edge k appears on audio_out with out_valid=1 after edge k; one cycle.
- Throughput: one sample per cycle when out_ready is held 1.
- audio_out and out_valid are registered. in_ready is combinational from out_valid and out_ready only; no combinational path from in_valid to in_ready.
- While out_valid=1 && out_ready=0, audio_out is stable.
- clip_flag updates on the same edge that registers the clamped output.

## Configuration
- ECHO_CANCEL_SAT_EN defined:
  - diff is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1];
  - clip_flag sets on any clamp and clears only on reset.
- Not defined:
  - diff is truncated to its low DATA_W bits (two's-complement wrap);
  - clip_flag is tied to 0.
- The same DATA_W-bit value is written to history, so recursion continues on the clamped or wrapped value.

## Structure
- Package echo_pkg holds:
  - DATA_W default;
  - sample_t typedef;
  - SAT_MAX / SAT_MIN constants;
  - the FILL/RUN state enum.
- The feed-forward echo stage imports the same package.
- Sub-module echo_history_ram: D × DATA_W circular memory with combinational read and synchronous write at one address; no reset. It must map to LUTRAM.
- The FSM, datapath and output register stay in the top module.

## Test plan
All scenarios use D=4, GAIN_SHIFT=1 unless noted.
- Impulse: x[0]=1000, then zeros, out_ready=1 → y = 1000,0,0,0, −500,0,0,0, 250,0,0,0, −125,0,0,0, 63.
- Round trip: feed the encoder output of a 1000 impulse (1000 at n=0, 500 at n=4, else 0) → y[0]=1000, y[4]=0, every other y=0.
- Saturation: x[0]=−32768, x[4]=30000, others 0.
  - With ECHO_CANCEL_SAT_EN: y[4]=32767 and clip_flag=1 from that output on.
  - Without the macro: y[4]=−19152 and clip_flag stays 0.
- Backpressure: after y[0] is presented, hold out_ready=0 for 3 cycles with in_valid=1 →
  - in_ready=0 and audio_out stays stable for those cycles;
  - after release, the stream is identical to the no-stall impulse result.
- Reset mid-stream: pulse rst_n low for 1 cycle after 6 impulse samples, then replay the impulse test →
  - outputs are 0 and out_valid=0 during reset;
  - the replayed output matches the impulse test exactly, with no residue from pre-reset history.
- Wrap: D=5, constant x=100 for 20 samples → ptr wraps without glitches, and y follows y[n] = 100 − (y[n−5] >>> 1) exactly.
